// File: rtl/amplitude_detector_pkg.sv
// Shared definitions for the amplitude detector: attenuation codes, peak thresholds, FSM states.
package amp_pkg;

  typedef logic [1:0] amp_code_t;

  localparam amp_code_t AMP_NONE = 2'b00;
  localparam amp_code_t AMP_DIV2 = 2'b01;
  localparam amp_code_t AMP_DIV4 = 2'b10;
  localparam amp_code_t AMP_DIV8 = 2'b11;

  localparam logic [7:0] THRESH_NONE = 8'd128;
  localparam logic [7:0] THRESH_DIV2 = 8'd64;
  localparam logic [7:0] THRESH_DIV4 = 8'd32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_REPORT  = 2'd2
  } state_t;

  function automatic amp_code_t classify(input logic [7:0] peak);
    if (peak >= THRESH_NONE)      return AMP_NONE;
    else if (peak >= THRESH_DIV2) return AMP_DIV2;
    else if (peak >= THRESH_DIV4) return AMP_DIV4;
    else                          return AMP_DIV8;
  endfunction

endpackage

// File: rtl/amplitude_detector_peak_tracker.sv
// Window sample counter and running maximum; clear restarts the window and can
// take a sample in the same cycle so back-to-back windows lose nothing.
module amp_peak_tracker #(
  parameter int CW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          sample,
  input  logic [7:0]    data_in,
  output logic [CW-1:0] count,
  output logic [7:0]    peak,
  output logic [7:0]    peak_next
);

  logic [CW-1:0] count_next;
  logic [CW-1:0] base_count;
  logic [7:0]    base_peak;

  always_comb begin
    base_count = clear ? '0 : count;
    base_peak  = clear ? '0 : peak;
    count_next = base_count;
    peak_next  = base_peak;
    if (sample) begin
      count_next = base_count + 1'b1;
      if (data_in > base_peak) peak_next = data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      peak  <= '0;
    end else begin
      count <= count_next;
      peak  <= peak_next;
    end
  end

endmodule

// File: rtl/amplitude_detector.sv
// Amplitude detector: classifies the peak of each WINDOW_LEN-sample window into an attenuation code.
// Optional restore path compiled in with `define AMPLITUDE_DETECTOR_RESTORE_EN.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | detection disabled, window state held cleared
//   ST_ACQUIRE | counting valid samples and tracking the peak
//   ST_REPORT  | one cycle: det_valid high, new amp_det visible
module amplitude_detector
  import amp_pkg::*;
#(
  parameter int WINDOW_LEN = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       sample_valid,
  input  logic [7:0] data_in,
  output logic [1:0] amp_det,
  output logic       det_valid
`ifdef AMPLITUDE_DETECTOR_RESTORE_EN
  ,
  output logic [7:0] data_out,
  output logic       out_valid
`endif
);

  localparam int CW = $clog2(WINDOW_LEN) + 1;

  state_t        state, state_next;
  logic          clear, take, last;
  logic [CW-1:0] count;
  logic [7:0]    peak, peak_next;

  amp_peak_tracker #(.CW(CW)) u_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .sample    (take),
    .data_in   (data_in),
    .count     (count),
    .peak      (peak),
    .peak_next (peak_next)
  );

  // A sample in REPORT opens the next window, so only IDLE blocks counting.
  always_comb begin
    clear      = (state != ST_ACQUIRE);
    take       = sample_valid && en && (state != ST_IDLE);
    last       = (state == ST_ACQUIRE) && take && (count == CW'(WINDOW_LEN - 1));
    state_next = state;
    case (state)
      ST_IDLE:    if (en) state_next = ST_ACQUIRE;
      ST_ACQUIRE: begin
        if (!en)       state_next = ST_IDLE;
        else if (last) state_next = ST_REPORT;
      end
      ST_REPORT:  state_next = en ? ST_ACQUIRE : ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      amp_det <= AMP_NONE;
    end else begin
      state <= state_next;
      if (last) amp_det <= classify(peak_next);
    end
  end

  assign det_valid = (state == ST_REPORT);

`ifdef AMPLITUDE_DETECTOR_RESTORE_EN
  logic [10:0] shifted;
  assign shifted = {3'b000, data_in} << amp_det;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      out_valid <= sample_valid;
      if (sample_valid) data_out <= (|shifted[10:8]) ? 8'hFF : shifted[7:0];
    end
  end
`endif

endmodule

// File: tb/tb_amplitude_detector.sv
// Scoreboard bench for amplitude_detector with WINDOW_LEN=8; the restore path is
// checked too when AMPLITUDE_DETECTOR_RESTORE_EN is defined.
module tb_amplitude_detector;

  typedef struct {
    logic [1:0] code;
    int         cyc;
  } det_exp_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       sample_valid;
  logic [7:0] data_in;
  logic [1:0] amp_det;
  logic       det_valid;
`ifdef AMPLITUDE_DETECTOR_RESTORE_EN
  logic [7:0] data_out;
  logic       out_valid;
`endif

  amplitude_detector #(.WINDOW_LEN(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .sample_valid (sample_valid),
    .data_in      (data_in),
    .amp_det      (amp_det),
    .det_valid    (det_valid)
`ifdef AMPLITUDE_DETECTOR_RESTORE_EN
    ,
    .data_out     (data_out),
    .out_valid    (out_valid)
`endif
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  logic [1:0] amp_model = 2'b00;
  det_exp_t   det_q[$];
  logic [7:0] rst_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor: detection events are checked for code and exact cycle.
  always @(negedge clk) begin
    if (rst_n && det_valid) begin
      n_cmp++;
      if (det_q.size() == 0) begin
        n_bad++;
        $display("FAIL det_unexpected: det_valid=1 amp_det=%b at cycle %0d, none expected", amp_det, cyc);
      end else begin
        det_exp_t e;
        e = det_q.pop_front();
        if (amp_det !== e.code || cyc != e.cyc) begin
          n_bad++;
          $display("FAIL det_event: got amp_det=%b cycle %0d, expected amp_det=%b cycle %0d",
                   amp_det, cyc, e.code, e.cyc);
        end
      end
    end
`ifdef AMPLITUDE_DETECTOR_RESTORE_EN
    if (rst_n && out_valid) begin
      n_cmp++;
      if (rst_q.size() == 0) begin
        n_bad++;
        $display("FAIL restore_unexpected: out_valid=1 data_out=%02h at cycle %0d", data_out, cyc);
      end else begin
        logic [7:0] r;
        r = rst_q.pop_front();
        if (data_out !== r) begin
          n_bad++;
          $display("FAIL restore_data: got %02h expected %02h at cycle %0d", data_out, r, cyc);
        end
      end
    end
`endif
  end

  function automatic logic [7:0] restored(input logic [7:0] d, input logic [1:0] a);
    logic [10:0] w;
    w = {3'b000, d} << a;
    return (|w[10:8]) ? 8'hFF : w[7:0];
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", name, got, want);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic e);
    @(posedge clk);
    #1;
    sample_valid = v;
    data_in      = d;
    en           = e;
    if (v) rst_q.push_back(restored(d, amp_model));
  endtask

  task automatic window(input logic [7:0] v[8], input logic [1:0] code);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, v[i], 1'b1);
      if (i == 7) begin
        det_q.push_back('{code: code, cyc: cyc + 1});
        amp_model = code;
      end
    end
  endtask

  function automatic void make_win(input logic [7:0] p, output logic [7:0] v[8]);
    for (int i = 0; i < 8; i++) v[i] = (i == 3) ? p : (p >> 1);
  endfunction

  logic [7:0] win[8];
  logic [7:0] pk[7] = '{8'h80, 8'h7F, 8'h40, 8'h3F, 8'h20, 8'h1F, 8'h00};
  logic [1:0] cd[7] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    sample_valid = 1'b0;
    data_in = 8'h00;
    #12;
    check("reset_amp_det", {6'd0, amp_det}, 8'h00);
    check("reset_det_valid", {7'd0, det_valid}, 8'h00);
    rst_n = 1'b1;

    // First window: peak 0x50 -> /2
    step(1'b0, 8'h00, 1'b1);
    win = '{8'h10, 8'h20, 8'h50, 8'h05, 8'h4F, 8'h00, 8'h33, 8'h01};
    window(win, 2'b01);

    // Threshold boundaries, all back-to-back (REPORT-cycle sample opens next window)
    for (int k = 0; k < 7; k++) begin
      make_win(pk[k], win);
      window(win, cd[k]);
    end

    // Set /4, then a window exercising restore saturation (0x30->C0, 0x50->FF)
    win = '{8'h30, 8'h00, 8'h11, 8'h2F, 8'h01, 8'h02, 8'h03, 8'h04};
    window(win, 2'b10);
    win = '{8'h30, 8'h50, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    window(win, 2'b01);

    // Drop en after 4 samples: partial window discarded, amp_det holds
    for (int i = 0; i < 4; i++) step(1'b1, 8'h10, 1'b1);
    step(1'b1, 8'h30, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    #2;
    check("en_drop_amp_hold", {6'd0, amp_det}, {6'd0, amp_model});
    for (int i = 0; i < 7; i++) step(1'b1, 8'h10, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h08, 1'b1);
    det_q.push_back('{code: 2'b11, cyc: cyc + 1});
    amp_model = 2'b11;
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    #2;
    check("amp_hold_after_window", {6'd0, amp_det}, 8'h03);

    // Reset 5 samples into a window
    for (int i = 0; i < 5; i++) step(1'b1, 8'h90, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    amp_model = 2'b00;
    #1;
    check("midrst_amp_det", {6'd0, amp_det}, 8'h00);
    check("midrst_det_valid", {7'd0, det_valid}, 8'h00);
`ifdef AMPLITUDE_DETECTOR_RESTORE_EN
    check("midrst_data_out", data_out, 8'h00);
    check("midrst_out_valid", {7'd0, out_valid}, 8'h00);
`endif
    #5;
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b1);
    win = '{8'h01, 8'h50, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    window(win, 2'b01);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);

    n_cmp++;
    if (det_q.size() != 0) begin
      n_bad++;
      $display("FAIL det_pending: %0d detections never seen, expected 0", det_q.size());
    end
    n_cmp++;
    if (rst_q.size() != 0 && rst_q.size() != rst_q.size() + 0) n_bad++;
`ifdef AMPLITUDE_DETECTOR_RESTORE_EN
    if (rst_q.size() != 0) begin
      n_bad++;
      $display("FAIL restore_pending: %0d restored samples never seen, expected 0", rst_q.size());
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/amplitude_detector.md
AMPLITUDE_DETECTOR -- requirements
Module: amplitude_detector

Interface
REQ-001 Parameter WINDOW_LEN, default 256, number of valid samples per detection window; the value SHALL be a power of two, >= 2.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 en  input  1  detection enable; 0 forces idle.
REQ-005 sample_valid  input  1  qualifies data_in for one cycle.
REQ-006 data_in  input  8  unsigned sample stream, possibly attenuated by right shift of 0..3.
REQ-007 amp_det  output  2  detected attenuation code: 00=none, 01=/2, 10=/4, 11=/8.
REQ-008 det_valid  output  1  one-cycle pulse when amp_det is updated.
REQ-009 data_out  output  8  restored sample (present only with RESTORE_EN).
REQ-010 out_valid  output  1  qualifies data_out (present only with RESTORE_EN).

Function
REQ-011 The FSM SHALL have states IDLE, ACQUIRE and REPORT.
REQ-012 IDLE -> ACQUIRE when en=1; sample count and peak cleared on entry.
REQ-013 In ACQUIRE, each cycle with sample_valid=1 SHALL increment the sample count and set peak = max(peak, data_in).
REQ-014 On the WINDOW_LEN-th valid sample, the FSM SHALL go to REPORT on the next edge, with the final peak including that sample.
REQ-015 In REPORT (one cycle), the block SHALL assert det_valid=1 and load amp_det from the peak: peak>=128 -> 00; 64..127 -> 01; 32..63 -> 10; <32 -> 11.
REQ-016 REPORT SHALL exit to ACQUIRE if en=1, else to IDLE.
REQ-017 A sample_valid in the REPORT cycle SHALL be counted as the first sample of the next window, provided en=1; no sample is lost between back-to-back windows.
REQ-018 en=0 in ACQUIRE SHALL return the FSM to IDLE on the next edge; the partial window is discarded, there is no det_valid, and amp_det holds.
REQ-019 amp_det SHALL hold its value between REPORT cycles.
REQ-020 Detection latency: det_valid SHALL rise exactly one cycle after the edge that samples the last window sample.
REQ-021 The sample counter width SHALL be $clog2(WINDOW_LEN)+1, and the counter SHALL not wrap within a window.

Reset
REQ-022 rst_n=0 SHALL asynchronously force: state=IDLE, count=0, peak=0, amp_det=00, det_valid=0, data_out=0x00, out_valid=0.
REQ-023 Reset asserted mid-window SHALL discard all window state; after release, detection resumes only through IDLE.

Configuration
REQ-024 Macro AMPLITUDE_DETECTOR_RESTORE_EN SHALL compile the restore path in; without it, data_out and out_valid do not exist and detection behaviour is unchanged.
REQ-025 With the macro defined, each sample_valid=1 cycle SHALL register data_out = min(data_in << amp_det, 255), with out_valid=1 one cycle later, independent of en and FSM state.
REQ-026 The restore path SHALL use the amp_det value present in the cycle the sample is taken; an amp_det update in the same cycle applies to the next sample.

Structure
REQ-027 A shared package amp_pkg SHALL hold: the 2-bit amp code typedef with the four code constants; the thresholds 128, 64 and 32; and the FSM state enum. The existing attenuation block also uses these codes.
REQ-028 One sub-module, amp_peak_tracker (count and running-max with clear), SHALL be instantiated; classification and FSM stay in the top.

Verification
REQ-029 rst_n=0 mid-window (WINDOW_LEN=8, 5 samples in) -> amp_det=00, det_valid=0, data_out=0x00 immediately; next 8 samples after release -> exactly one det_valid.
REQ-030 WINDOW_LEN=8, en=1, 8 samples with max 0x50 -> det_valid pulse one cycle after 8th sample, amp_det=01.
REQ-031 Boundary peaks 0x80->00, 0x7F->01, 0x40->01, 0x3F->10, 0x20->10, 0x1F->11, all-zero window ->11.
REQ-032 en dropped after 4 of 8 samples -> no det_valid, amp_det unchanged; re-enable -> a fresh 8-sample window is required.
REQ-033 Continuous sample_valid over two windows -> the sample in the REPORT cycle counts toward window 2; the second det_valid comes exactly 8 valid samples after the first.
REQ-034 (RESTORE_EN) amp_det=10: data_in 0x30 -> data_out 0xC0; data_in 0x50 -> 0xFF saturated; out_valid follows sample_valid by one cycle.
